imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Serial boot loader sitting directly upstream of the single-cycle core's instruction memory. It receives a program image over a UART line (8N1) and packs little-endian bytes into 32-bit instruction words. It writes each word into instruction memory through a one-cycle write strobe. The core is held in reset until the declared word count has been written.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clk cycles per UART bit (100 MHz / 115200). Must be an even number ≥ 4.
- `BUS_WIDTH`, default 32: instruction word and address width.
- `DEPTH`, default 256: instruction memory capacity in words.

Ports:
- `clk` in, 1: clock.
- `rst` in, 1: reset, synchronous, active-low.
- `rx` in, 1: UART serial input. Idle high, asynchronous to clk.
- `i_mem_wr_en` out, 1: one-cycle instruction memory write strobe.
- `i_mem_wr_addr` out, BUS_WIDTH: byte address of the word being written (word_index × 4).
- `i_mem_wr_data` out, BUS_WIDTH: assembled instruction word.
- `cpu_rst_n` out, 1: reset for the core. Low while loading.
- `load_done` out, 1: high once the image is complete. Sticky until rst.
- `frame_err` out, 1: sticky; set on any bad stop bit.

## Operation
- **Reset values** (rst low at posedge):
  - All outputs 0: `cpu_rst_n` = 0, `load_done` = 0, `frame_err` = 0, `i_mem_wr_en` = 0, addr/data = 0.
  - Loader returns to `HDR_LO`; the RX FSM returns to `IDLE`; the synchronizer is preset to 1.
  - Reset mid-byte or mid-image discards all partial state.
- **RX front end**:
  - `rx` passes through a 2-flop synchronizer; `rxs` is the second flop.
  - RX FSM states: `IDLE` → `START` → `DATA` → `STOP` → `IDLE`.
  - `IDLE`: `rxs` = 0 starts the bit counter and enters `START`.
  - `START`: after CLKS_PER_BIT/2 cycles, re-sample. If `rxs` = 1 it is a glitch; return to `IDLE` with no byte. Otherwise enter `DATA`.
  - `DATA`: sample 8 bits, LSB first, each CLKS_PER_BIT cycles after the previous sample.
  - `STOP`: sample CLKS_PER_BIT after bit 7.
    - Stop = 1: pulse internal `byte_valid` for one cycle with the byte.
    - Stop = 0: set `frame_err`, discard the byte, no `byte_valid`.
  - Return to `IDLE` either way. Loader state is untouched by a discarded byte.
- **Loader FSM** (advances only on `byte_valid`):
  - `HDR_LO`: byte → N[7:0].
  - `HDR_HI`: byte → N[15:8]. If N = 0, go to `DONE`; else go to `WORD`, with word_index = 0 and byte_sel = 0.
  - `WORD`: byte placed in word[8·byte_sel +: 8] (little-endian); byte_sel increments.
    - On byte_sel = 3: write the word, reset byte_sel to 0, increment word_index.
    - After writing word N−1, go to `DONE`.
  - `DONE`: all further bytes are ignored. `load_done` = 1, `cpu_rst_n` = 1.
- **Writes**:
  - `i_mem_wr_en` pulses one cycle per word.
  - addr = word_index × 4, width BUS_WIDTH, zero-extended.
  - Addr/data hold their last values while the strobe is low.
- **Overflow**:
  - Words with word_index ≥ DEPTH are still received and counted toward N, but suppress `i_mem_wr_en`.
  - `DONE` is still reached after N words.
- `frame_err` has no effect on `cpu_rst_n`. Software verifies the image.

## Timing
- The synchronizer adds 2 cycles from the `rx` falling edge to start detection.
- Stop sample occurs 9·CLKS_PER_BIT + CLKS_PER_BIT/2 cycles after start detection.
- `byte_valid` is high the cycle after the stop sample.
- `i_mem_wr_en` is registered: high the cycle after the `byte_valid` of byte 3 of a word.
- `load_done` and `cpu_rst_n` rise together, one cycle after the final `i_mem_wr_en`. For N = 0, they rise one cycle after the `HDR_HI` `byte_valid`.
- Back-to-back frames (next start bit immediately after the stop bit) must be received without loss. The RX FSM re-enters `IDLE` in time to detect the next start.
- A minimum `rx` low pulse of < CLKS_PER_BIT/2 cycles is rejected as a glitch.

## Test plan
All scenarios use CLKS_PER_BIT = 8, DEPTH = 4.
1. Reset hold: rst low 3 cycles, rx = 1 → all outputs 0 and stay 0 for 200 cycles with rx idle.
2. Single-word image:
   - Stimulus: bytes 01 00 13 05 A0 00, back-to-back.
   - Response: exactly one `i_mem_wr_en` pulse with addr 0x0 and data 0x00A00513.
   - `load_done` = `cpu_rst_n` = 1 one cycle after that pulse.
3. Multi-word image:
   - Stimulus: N = 3 (03 00), then words 0x11111111, 0x22222222, 0x33333333.
   - Response: writes at addresses 0x0/0x4/0x8 in order, no other strobes, then `DONE`; bytes sent afterwards produce no strobes.
4. Framing error and glitch:
   - Stimulus: a frame with stop bit = 0 mid-word, followed by a 3-cycle low glitch on rx.
   - Response: `frame_err` = 1, the byte is dropped, and there is no `byte_valid` for the glitch. The next 4 good bytes complete the word with the correct data.
5. Overflow:
   - Stimulus: N = 5 with DEPTH = 4.
   - Response: 4 strobes (addresses 0x0 to 0xC), no strobe for word 4, `load_done` after the 5th word's last byte.
6. Reset mid-load:
   - Stimulus: rst asserted after header plus 2 bytes, then a new image N = 1 with word 0xDEADBEEF.
   - Response: a single write of 0xDEADBEEF at addr 0x0; no stale bytes merged.
   - N = 0 variant: `cpu_rst_n` rises one cycle after the second header byte with no strobes.

Source files
------------

// File: rtl/imem_boot_loader.sv
// UART (8N1) boot loader: assembles little-endian bytes into instruction words,
// writes them into instruction memory and holds the core in reset until the image is in.
module imem_boot_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int BUS_WIDTH    = 32,
    parameter int DEPTH        = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 i_mem_wr_en,
    output logic [BUS_WIDTH-1:0] i_mem_wr_addr,
    output logic [BUS_WIDTH-1:0] i_mem_wr_data,
    output logic                 cpu_rst_n,
    output logic                 load_done,
    output logic                 frame_err
);

    localparam int              CW      = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0]   HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [31:0]     DEPTH_W = DEPTH;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] LD_HDR_LO = 2'd0;
    localparam logic [1:0] LD_HDR_HI = 2'd1;
    localparam logic [1:0] LD_WORD   = 2'd2;
    localparam logic [1:0] LD_DONE   = 2'd3;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rxs;

    logic [1:0]           r_rx_state;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_byte_valid;
    logic [7:0]           r_byte;
    logic                 r_frame_err;

    logic [1:0]           r_ld_state;
    logic [15:0]          r_n;
    logic [15:0]          r_word_idx;
    logic [1:0]           r_byte_sel;
    logic [BUS_WIDTH-1:0] r_word;
    logic                 r_wr_en;
    logic [BUS_WIDTH-1:0] r_wr_addr;
    logic [BUS_WIDTH-1:0] r_wr_data;
    logic                 r_fin_pend;
    logic                 r_load_done;

    logic [BUS_WIDTH-1:0] w_word_full;
    logic                 w_in_range;
    logic                 w_last;

    // Preset to idle-high so leaving reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_state   <= RX_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!w_rxs) begin
                        r_rx_state <= RX_START;
                        r_cnt      <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt      <= '0;
                        r_bit_idx  <= '0;
                        r_rx_state <= w_rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxs, r_shift[7:1]};
                        if (r_bit_idx == 3'd7)
                            r_rx_state <= RX_STOP;
                        else
                            r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    // Sampled mid stop bit; the remaining half bit leaves time to catch a back-to-back start.
                    if (r_cnt == FULL_M1) begin
                        r_cnt      <= '0;
                        r_rx_state <= RX_IDLE;
                        if (w_rxs) begin
                            r_byte_valid <= 1'b1;
                            r_byte       <= r_shift;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    always_comb begin
        w_word_full        = r_word;
        w_word_full[31:24] = r_byte;
        w_in_range         = (32'(r_word_idx) < DEPTH_W);
        w_last             = (r_word_idx == r_n - 16'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ld_state  <= LD_HDR_LO;
            r_n         <= '0;
            r_word_idx  <= '0;
            r_byte_sel  <= '0;
            r_word      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_fin_pend  <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_wr_en    <= 1'b0;
            r_fin_pend <= 1'b0;
            if (r_fin_pend)
                r_load_done <= 1'b1;
            if (r_byte_valid) begin
                case (r_ld_state)
                    LD_HDR_LO: begin
                        r_n[7:0]   <= r_byte;
                        r_ld_state <= LD_HDR_HI;
                    end
                    LD_HDR_HI: begin
                        r_n[15:8]  <= r_byte;
                        r_word_idx <= '0;
                        r_byte_sel <= '0;
                        if ({r_byte, r_n[7:0]} == 16'd0) begin
                            r_ld_state  <= LD_DONE;
                            r_load_done <= 1'b1;
                        end else begin
                            r_ld_state <= LD_WORD;
                        end
                    end
                    LD_WORD: begin
                        r_word[{r_byte_sel, 3'b000} +: 8] <= r_byte;
                        r_byte_sel <= r_byte_sel + 1'b1;
                        if (r_byte_sel == 2'd3) begin
                            // Out-of-range words still count toward N but never reach memory.
                            if (w_in_range) begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= BUS_WIDTH'({r_word_idx, 2'b00});
                                r_wr_data <= w_word_full;
                            end
                            r_word_idx <= r_word_idx + 16'd1;
                            if (w_last) begin
                                r_ld_state <= LD_DONE;
                                r_fin_pend <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign i_mem_wr_en   = r_wr_en;
    assign i_mem_wr_addr = r_wr_addr;
    assign i_mem_wr_data = r_wr_data;
    assign load_done     = r_load_done;
    assign cpu_rst_n     = r_load_done;
    assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: table of byte images with expected writes,
// plus hand-written framing/glitch, reset and N=0 sequences.
module tb_imem_boot_loader;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx  = 1'b1;
    logic        i_mem_wr_en;
    logic [31:0] i_mem_wr_addr;
    logic [31:0] i_mem_wr_data;
    logic        cpu_rst_n;
    logic        load_done;
    logic        frame_err;

    imem_boot_loader #(.CLKS_PER_BIT(CPB), .BUS_WIDTH(32), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .i_mem_wr_en  (i_mem_wr_en),
        .i_mem_wr_addr(i_mem_wr_addr),
        .i_mem_wr_data(i_mem_wr_data),
        .cpu_rst_n    (cpu_rst_n),
        .load_done    (load_done),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ncmp = 0;
    int nerr = 0;

    logic [31:0] wa [16];
    logic [31:0] wd [16];
    int          wc [16];
    int          nwr;
    bit          done_seen;
    int          done_cyc;

    always @(negedge clk) begin
        if (!rst) begin
            nwr       = 0;
            done_seen = 1'b0;
            done_cyc  = 0;
        end else begin
            if (i_mem_wr_en) begin
                if (nwr < 16) begin
                    wa[nwr] = i_mem_wr_addr;
                    wd[nwr] = i_mem_wr_data;
                    wc[nwr] = cyc;
                end
                nwr++;
            end
            if (load_done && !done_seen) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
    end

    typedef struct packed {
        logic [7:0]        nb;
        logic [23:0][7:0]  b;
        logic [7:0]        nw;
        logic [4:0][31:0]  a;
        logic [4:0][31:0]  d;
        logic [7:0]        last_idx;
        logic              wr_t;
    } vec_t;

    vec_t vecs [3];
    int   last_start;
    int   tgt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rx  = 1'b1;
        rst = 1'b0;
        idle(3);
        rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        last_start = cyc;
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
    endtask

    initial begin
        vecs[0] = '0;
        vecs[0].nb = 8'd6;
        vecs[0].b[5:0] = {8'h00, 8'hA0, 8'h05, 8'h13, 8'h00, 8'h01};
        vecs[0].nw = 8'd1;
        vecs[0].d[0] = 32'h00A00513;
        vecs[0].last_idx = 8'd5;
        vecs[0].wr_t = 1'b1;

        vecs[1] = '0;
        vecs[1].nb = 8'd18;
        vecs[1].b[0] = 8'h03;
        for (int i = 0; i < 12; i++) vecs[1].b[2+i] = 8'((i / 4 + 1) * 17);
        for (int i = 14; i < 18; i++) vecs[1].b[i] = 8'h44;
        vecs[1].nw = 8'd3;
        for (int k = 0; k < 3; k++) begin
            vecs[1].a[k] = 32'(k * 4);
            vecs[1].d[k] = 32'h11111111 * 32'(k + 1);
        end
        vecs[1].last_idx = 8'd13;
        vecs[1].wr_t = 1'b1;

        vecs[2] = '0;
        vecs[2].nb = 8'd22;
        vecs[2].b[0] = 8'h05;
        for (int i = 0; i < 20; i++) vecs[2].b[2+i] = 8'((i / 4) * 16 + (i % 4));
        vecs[2].nw = 8'd4;
        for (int k = 0; k < 4; k++) begin
            vecs[2].a[k] = 32'(k * 4);
            vecs[2].d[k] = 32'h03020100 + 32'h10101010 * 32'(k);
        end
        vecs[2].last_idx = 8'd21;
        vecs[2].wr_t = 1'b0;

        // Reset hold
        begin
            bit bad;
            do_reset();
            chk("reset_outputs", {26'd0, i_mem_wr_en, cpu_rst_n, load_done, frame_err, |i_mem_wr_addr, |i_mem_wr_data}, 32'd0);
            bad = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (i_mem_wr_en || cpu_rst_n || load_done || frame_err || (|i_mem_wr_addr) || (|i_mem_wr_data))
                    bad = 1'b1;
                idle(1);
            end
            chk("reset_idle_200", {31'd0, bad}, 32'd0);
        end

        // Table-driven images
        for (int v = 0; v < 3; v++) begin
            do_reset();
            tgt = 0;
            for (int i = 0; i < int'(vecs[v].nb); i++) begin
                send_byte(vecs[v].b[i], 1'b1);
                if (i == int'(vecs[v].last_idx)) tgt = last_start;
            end
            idle(30);
            chk($sformatf("v%0d_nwr", v), nwr, 32'(vecs[v].nw));
            for (int k = 0; k < int'(vecs[v].nw); k++) begin
                chk($sformatf("v%0d_addr%0d", v, k), wa[k], vecs[v].a[k]);
                chk($sformatf("v%0d_data%0d", v, k), wd[k], vecs[v].d[k]);
            end
            chk($sformatf("v%0d_load_done", v), {31'd0, load_done}, 32'd1);
            chk($sformatf("v%0d_cpu_rst_n", v), {31'd0, cpu_rst_n}, 32'd1);
            chk($sformatf("v%0d_frame_err", v), {31'd0, frame_err}, 32'd0);
            chk($sformatf("v%0d_done_cyc", v), done_cyc, tgt + 81);
            if (vecs[v].wr_t && nwr > 0)
                chk($sformatf("v%0d_last_wr_cyc", v), wc[nwr-1], tgt + 80);
        end

        // Framing error followed by a glitch, then a good word
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("ferr_before", {31'd0, frame_err}, 32'd0);
        send_byte(8'hFF, 1'b0);
        rx = 1'b1;
        idle(20);
        chk("ferr_set", {31'd0, frame_err}, 32'd1);
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(20);
        chk("ferr_no_wr_yet", nwr, 32'd0);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        idle(30);
        chk("ferr_nwr", nwr, 32'd1);
        chk("ferr_addr", wa[0], 32'h0);
        chk("ferr_data", wd[0], 32'h12345678);
        chk("ferr_done", {31'd0, load_done}, 32'd1);
        chk("ferr_sticky", {31'd0, frame_err}, 32'd1);

        // Reset mid-load, then a fresh one-word image
        do_reset();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        do_reset();
        chk("midrst_cleared", {30'd0, load_done, |i_mem_wr_data}, 32'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hDE, 1'b1);
        idle(30);
        chk("midrst_nwr", nwr, 32'd1);
        chk("midrst_addr", wa[0], 32'h0);
        chk("midrst_data", wd[0], 32'hDEADBEEF);
        chk("midrst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);

        // Empty image
        do_reset();
        send_byte(8'h00, 1'b1);
        chk("n0_not_done_yet", {31'd0, cpu_rst_n}, 32'd0);
        send_byte(8'h00, 1'b1);
        tgt = last_start;
        idle(20);
        chk("n0_nwr", nwr, 32'd0);
        chk("n0_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        chk("n0_load_done", {31'd0, load_done}, 32'd1);
        chk("n0_done_cyc", done_cyc, tgt + 80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
